width_reducer: RTL and testbench

WIDTH_REDUCER -- requirements
Module: width_reducer

---
 rtl/arith_pkg.sv | 12 +
 rtl/width_reducer_if.sv | 25 ++
 rtl/round_const.sv | 29 ++
 rtl/width_reducer.sv | 86 ++++++++
 tb/tb_width_reducer.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: rounding mode encodings used by the
// word-length reduction blocks.
package arith_pkg;

    typedef enum logic [1:0] {
        TRUNCATE      = 2'd0,
        ROUND_UP      = 2'd1,
        ROUND_TO_ZERO = 2'd2,
        ROUND_TO_EVEN = 2'd3
    } round_mode_e;

endpackage

// File: rtl/width_reducer_if.sv
// Input/output sample streams of the width reducer, each a valid/ready
// channel. The master side produces input samples and consumes outputs.
interface width_reducer_if #(
    parameter int IW = 16,
    parameter int OW = 12
);
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_data;
    logic [1:0]    in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic          out_ovf;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/round_const.sv
// Rounding constant added to a sign-extended sample before its D low bits
// are dropped; selects truncate / half-up / half-to-zero / half-to-even.
module round_const
    import arith_pkg::*;
#(
    parameter int IW = 16,
    parameter int D  = 4
) (
    input  logic [IW-1:0] data,
    input  round_mode_e   mode,
    output logic [IW:0]   k
);
    localparam logic [IW:0] ONE  = {{IW{1'b0}}, 1'b1};
    localparam logic [IW:0] HALF = ONE << (D-1);

    // Only the sign bit and the lowest kept bit influence the constant.
    logic unused_data;
    assign unused_data = ^data;

    always_comb begin
        k = '0;
        case (mode)
            ROUND_UP:      k = HALF;
            ROUND_TO_ZERO: k = data[IW-1] ? HALF : HALF - ONE;
            ROUND_TO_EVEN: k = HALF - ONE + {{IW{1'b0}}, data[D]};
            default:       k = '0;
        endcase
    end
endmodule

// File: rtl/width_reducer.sv
// Two-stage signed width reducer: stage 1 registers the rounded value,
// stage 2 registers the saturated/wrapped result and counts overflows.
module width_reducer
    import arith_pkg::*;
#(
    parameter int IW  = 16,
    parameter int OW  = 12,
    parameter int SAT = 1,
    parameter int CW  = 16
) (
    input  logic              clk,
    input  logic              rst,
    width_reducer_if.slave    bus,
    input  logic              ovf_clr,
    output logic [CW-1:0]     ovf_cnt
);
    localparam int D = IW - OW;
    localparam logic [OW-1:0] MAX_POS = {1'b0, {(OW-1){1'b1}}};
    localparam logic [OW-1:0] MAX_NEG = {1'b1, {(OW-1){1'b0}}};

    logic          en;
    logic [IW:0]   k;
    logic [IW:0]   sum_d;
    logic          s1_valid;
    logic [OW:0]   s1_r;
    logic          s2_valid;
    logic [OW-1:0] s2_data;
    logic          s2_ovf;
    logic          ovf;
    logic [OW-1:0] res;
    logic          unused_frac;

    // One enable for the whole pipe: it moves only when the output slot frees up.
    assign en           = !s2_valid || bus.out_ready;
    assign bus.in_ready = en;

    round_const #(.IW(IW), .D(D)) u_round_const (
        .data (bus.in_data),
        .mode (round_mode_e'(bus.in_mode)),
        .k    (k)
    );

    assign sum_d       = {bus.in_data[IW-1], bus.in_data} + k;
    assign unused_frac = ^sum_d[D-1:0];

    // r is OW+1 bits; it fits in OW bits exactly when its top two bits agree.
    always_comb begin
        ovf = s1_r[OW] ^ s1_r[OW-1];
        res = s1_r[OW-1:0];
        if (ovf && SAT != 0) begin
            res = s1_r[OW] ? MAX_NEG : MAX_POS;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_r     <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_ovf   <= 1'b0;
        end else if (en) begin
            s1_valid <= bus.in_valid;
            s2_valid <= s1_valid;
            if (bus.in_valid) begin
                s1_r <= sum_d[IW:D];
            end
            if (s1_valid) begin
                s2_data <= res;
                s2_ovf  <= ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || ovf_clr) begin
            ovf_cnt <= '0;
        end else if (s2_valid && bus.out_ready && s2_ovf && ovf_cnt != {CW{1'b1}}) begin
            ovf_cnt <= ovf_cnt + 1'b1;
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_data  = s2_data;
    assign bus.out_ovf   = s2_ovf;
endmodule

// File: tb/tb_width_reducer.sv
// Scoreboard bench: a clamping instance and a wrapping instance with a 2-bit
// overflow counter share one input stream; a monitor checks every output.
module tb_width_reducer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ovf_clr;
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    initial forever #5 clk = ~clk;

    width_reducer_if #(.IW(16), .OW(12)) bus0 ();
    width_reducer_if #(.IW(16), .OW(12)) bus1 ();

    assign bus1.in_valid  = bus0.in_valid;
    assign bus1.in_data   = bus0.in_data;
    assign bus1.in_mode   = bus0.in_mode;
    assign bus1.out_ready = bus0.out_ready;

    width_reducer #(.IW(16), .OW(12), .SAT(1), .CW(16)) dut_sat (
        .clk(clk), .rst(rst), .bus(bus0), .ovf_clr(ovf_clr), .ovf_cnt(cnt0)
    );

    width_reducer #(.IW(16), .OW(12), .SAT(0), .CW(2)) dut_wrap (
        .clk(clk), .rst(rst), .bus(bus1), .ovf_clr(ovf_clr), .ovf_cnt(cnt1)
    );

    typedef struct {
        logic [11:0] sat;
        logic [11:0] wrp;
        logic        ovf;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        sb[$];
    int          total  = 0;
    int          passed = 0;
    int          cyc    = 0;
    bit          mon_held = 1'b0;
    logic [11:0] mon_hd;
    logic        mon_ho;
    exp_t        mon_e;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [15:0] d, input logic [1:0] m,
                        input logic [11:0] es, input logic [11:0] ew,
                        input logic eo, input bit lat);
        int   n    = 0;
        bit   done = 1'b0;
        exp_t e;
        bus0.in_valid = 1'b1;
        bus0.in_data  = d;
        bus0.in_mode  = m;
        while (!done) begin
            @(negedge clk);
            if (bus0.in_ready) begin
                e = '{es, ew, eo, cyc, lat};
                sb.push_back(e);
                done = 1'b1;
            end else if (++n > 50) begin
                chk("send_timeout", 32'd0, 32'd1);
                done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        bus0.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every output transfer, checks hold under stall.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            mon_held = 1'b0;
        end else begin
            if (mon_held) begin
                chk("stall_hold_data", bus0.out_data, mon_hd);
                chk("stall_hold_ovf", bus0.out_ovf, mon_ho);
            end
            mon_held = bus0.out_valid && !bus0.out_ready;
            mon_hd   = bus0.out_data;
            mon_ho   = bus0.out_ovf;
            if (bus0.out_valid && bus0.out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_output: actual data %0h, required no output", bus0.out_data);
                end else begin
                    mon_e = sb.pop_front();
                    chk("data_sat", bus0.out_data, mon_e.sat);
                    chk("data_wrap", bus1.out_data, mon_e.wrp);
                    chk("ovf_sat", bus0.out_ovf, mon_e.ovf);
                    chk("ovf_wrap", bus1.out_ovf, mon_e.ovf);
                    chk("valid_wrap", bus1.out_valid, 32'd1);
                    if (mon_e.lat) chk("latency", cyc - mon_e.acc, 32'd2);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int n;
        rst            = 1'b1;
        ovf_clr        = 1'b0;
        bus0.in_valid  = 1'b0;
        bus0.in_data   = '0;
        bus0.in_mode   = '0;
        bus0.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", bus0.out_valid, 32'd0);
        chk("reset_out_data", bus0.out_data, 32'd0);
        chk("reset_out_ovf", bus0.out_ovf, 32'd0);
        chk("reset_cnt", cnt0, 32'd0);
        chk("reset_cnt_wrap", cnt1, 32'd0);
        chk("reset_in_ready", bus0.in_ready, 32'd1);
        rst = 1'b0;

        // rounding modes back-to-back, then signed and boundary vectors
        send(16'h0018, 2'd0, 12'h001, 12'h001, 1'b0, 1'b1);
        send(16'h0018, 2'd1, 12'h002, 12'h002, 1'b0, 1'b1);
        send(16'h0018, 2'd2, 12'h001, 12'h001, 1'b0, 1'b1);
        send(16'h0018, 2'd3, 12'h002, 12'h002, 1'b0, 1'b1);
        send(16'hFFE8, 2'd2, 12'hFFF, 12'hFFF, 1'b0, 1'b1);
        send(16'h0028, 2'd3, 12'h002, 12'h002, 1'b0, 1'b1);
        send(16'h0038, 2'd3, 12'h004, 12'h004, 1'b0, 1'b1);
        send(16'hFFF8, 2'd0, 12'hFFF, 12'hFFF, 1'b0, 1'b1);
        send(16'hFFF8, 2'd1, 12'h000, 12'h000, 1'b0, 1'b1);
        send(16'hFFF8, 2'd2, 12'h000, 12'h000, 1'b0, 1'b1);
        send(16'hFFF8, 2'd3, 12'h000, 12'h000, 1'b0, 1'b1);
        send(16'hFFE8, 2'd3, 12'hFFE, 12'hFFE, 1'b0, 1'b1);
        send(16'h8000, 2'd0, 12'h800, 12'h800, 1'b0, 1'b1);
        send(16'h8000, 2'd2, 12'h800, 12'h800, 1'b0, 1'b1);
        send(16'h7FF7, 2'd1, 12'h7FF, 12'h7FF, 1'b0, 1'b1);
        send(16'h7FF8, 2'd0, 12'h7FF, 12'h7FF, 1'b0, 1'b1);
        send(16'h7FF8, 2'd2, 12'h7FF, 12'h7FF, 1'b0, 1'b1);
        drain();
        chk("cnt_no_ovf", cnt0, 32'd0);

        // positive overflow: clamp vs wrap
        send(16'h7FF8, 2'd1, 12'h7FF, 12'h800, 1'b1, 1'b1);
        drain();
        chk("cnt_after_1", cnt0, 32'd1);
        chk("cnt_wrap_after_1", cnt1, 32'd1);
        send(16'h7FF8, 2'd3, 12'h7FF, 12'h800, 1'b1, 1'b1);
        drain();
        chk("cnt_after_2", cnt0, 32'd2);

        // three-cycle downstream stall mid-stream
        send(16'h0010, 2'd0, 12'h001, 12'h001, 1'b0, 1'b0);
        send(16'h0020, 2'd0, 12'h002, 12'h002, 1'b0, 1'b0);
        bus0.out_ready = 1'b0;
        bus0.in_valid  = 1'b1;
        bus0.in_data   = 16'h0030;
        bus0.in_mode   = 2'd0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", bus0.in_ready, 32'd0);
            chk("stall_out_valid", bus0.out_valid, 32'd1);
            @(posedge clk);
            #1;
        end
        bus0.out_ready = 1'b1;
        send(16'h0030, 2'd0, 12'h003, 12'h003, 1'b0, 1'b0);
        drain();

        // reset with two overflowing samples in flight
        bus0.out_ready = 1'b0;
        send(16'h7FF8, 2'd1, 12'h7FF, 12'h800, 1'b1, 1'b0);
        send(16'h7FF8, 2'd1, 12'h7FF, 12'h800, 1'b1, 1'b0);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus0.out_ready = 1'b1;
        chk("midrst_out_valid", bus0.out_valid, 32'd0);
        chk("midrst_cnt", cnt0, 32'd0);
        chk("midrst_cnt_wrap", cnt1, 32'd0);
        chk("midrst_in_ready", bus0.in_ready, 32'd1);
        repeat (6) @(posedge clk);
        #1;

        // clear coincident with an overflowed transfer
        send(16'h7FF8, 2'd1, 12'h7FF, 12'h800, 1'b1, 1'b0);
        drain();
        chk("cnt_before_clr", cnt0, 32'd1);
        send(16'h7FF8, 2'd1, 12'h7FF, 12'h800, 1'b1, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus0.out_valid && n < 20);
        if (!bus0.out_valid) chk("clr_wait_timeout", bus0.out_valid, 32'd1);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        chk("cnt_clr_priority", cnt0, 32'd0);
        chk("cnt_wrap_clr_priority", cnt1, 32'd0);

        // four overflows: the 2-bit counter must stick at 3
        repeat (4) send(16'h7FF8, 2'd1, 12'h7FF, 12'h800, 1'b1, 1'b0);
        drain();
        chk("cnt_after_4", cnt0, 32'd4);
        chk("cnt_wrap_saturate", cnt1, 32'd3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
